// File: rtl/quad_gen_pkg.sv
// Shared types and defaults for the quad_gen function generator.
package quad_gen_pkg;

  typedef enum logic [1:0] {
    FUNC_ADD = 2'b00,
    FUNC_SUB = 2'b01,
    FUNC_MUL = 2'b10,
    FUNC_XOR = 2'b11
  } func_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/quad_gen_core.sv
// Combinational datapath: selects one of four modulo-2^WIDTH functions of a and b.
module quad_gen_core
  import quad_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_result
);

  // All operations are evaluated in a WIDTH-bit context, so carries and high
  // product bits are dropped by the assignment itself.
  always_comb begin
    next_result = '0;
    case (func_e'(func))
      FUNC_ADD: next_result = a + b;
      FUNC_SUB: next_result = a - b;
      FUNC_MUL: next_result = a * b;
      FUNC_XOR: next_result = a ^ b;
      default:  next_result = '0;
    endcase
  end

endmodule

// File: rtl/quad_gen.sv
// Registered function generator: one-cycle latency, async active-low reset.
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] next_result;

  quad_gen_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .func        (func),
    .a           (a),
    .b           (b),
    .next_result (next_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= next_result;
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: driver queues hand-computed results, monitor checks them.
module tb_quad_gen;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] expq[$];
  int               nvec;
  int               nbad;

  quad_gen #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .func   (func),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: result=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one queued expectation is retired per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    logic [WIDTH-1:0] e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("scoreboard", result, e);
    end
  end

  task automatic vec(input logic r, input logic [1:0] f, input logic [WIDTH-1:0] va,
                     input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    rst_n = r;
    func  = f;
    a     = va;
    b     = vb;
    @(posedge clk);
    expq.push_back(exp);
  endtask

  initial begin
    nvec  = 0;
    nbad  = 0;
    rst_n = 1'b0;
    func  = 2'b00;
    a     = 4'd6;
    b     = 4'd3;
    #2;
    check("reset_initial", result, 4'd0);

    // Reset held with clocks running
    repeat (3) vec(1'b0, 2'b00, 4'd6, 4'd3, 4'd0);
    vec(1'b1, 2'b00, 4'd6, 4'd3, 4'd9);

    // Function sweep a=6 b=3
    vec(1'b1, 2'b01, 4'd6, 4'd3, 4'd3);
    vec(1'b1, 2'b10, 4'd6, 4'd3, 4'd2);
    vec(1'b1, 2'b11, 4'd6, 4'd3, 4'd5);

    // Wrap boundaries
    vec(1'b1, 2'b00, 4'd15, 4'd1,  4'd0);
    vec(1'b1, 2'b01, 4'd3,  4'd6,  4'd13);
    vec(1'b1, 2'b10, 4'd15, 4'd15, 4'd1);
    vec(1'b1, 2'b11, 4'd15, 4'd15, 4'd0);
    vec(1'b1, 2'b10, 4'd7,  4'd5,  4'd3);
    vec(1'b1, 2'b01, 4'd0,  4'd1,  4'd15);

    // Mid-cycle operand change only takes effect on the next edge
    vec(1'b1, 2'b00, 4'd6, 4'd3, 4'd9);
    #2;
    a = 4'd7;
    #1;
    check("midcycle_hold", result, 4'd9);
    @(posedge clk);
    expq.push_back(4'd10);
    repeat (10) vec(1'b1, 2'b00, 4'd7, 4'd3, 4'd10);

    // Async reset between edges
    vec(1'b1, 2'b00, 4'd6, 4'd3, 4'd9);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", result, 4'd0);
    vec(1'b0, 2'b00, 4'd6, 4'd3, 4'd0);
    vec(1'b1, 2'b00, 4'd6, 4'd3, 4'd9);

    // Undriven func after reset release
    vec(1'b0, 2'b00, 4'd0, 4'd0, 4'd0);
    vec(1'b1, 2'bxx, 4'd0, 4'd0, 4'd0);

    repeat (3) @(posedge clk);
    #2;
    nvec++;
    if (expq.size() != 0) begin
      nbad++;
      $display("FAIL queue_drain: pending=%0d expected=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time=%0t expected completion before 20000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
